// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: queues register-write requests in a small FIFO and issues
// them one per cycle as registered write strobes to a 7-entry register file.
// Index 7 is illegal: it is handshaken, dropped, and flagged in illegal_err.
module reg_write_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_idx,
  input  logic [DATA_W-1:0]        req_data,
  input  logic                     wb_stall,
  output logic                     wr_en,
  output logic [2:0]               wr_sel,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     illegal_err,
  input  logic                     err_clr,
  output logic [7:0]               wr_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [2:0]        idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;
  logic               wr_en_q,  wr_en_d;
  logic [2:0]         wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [7:0]         wr_count_q, wr_count_d;
  logic               err_q,    err_d;

  logic accept, push, pop, illegal_acc;
  entry_t head;

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // never reopens a full FIFO; reset forces it low.
  assign req_ready   = (level_q < FULL_LVL) && rst_n;
  assign accept      = req_valid && req_ready;
  assign illegal_acc = accept && (req_idx == 3'd7);
  assign push        = accept && (req_idx != 3'd7);
  // Pop only from entries already stored: no same-cycle pass-through.
  assign pop         = (level_q != '0) && !wb_stall;
  assign head        = mem_q[rd_ptr_q];

  // Next-state for FIFO storage, pointers, occupancy and write port.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    wr_en_d    = 1'b0;
    wr_sel_d   = wr_sel_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;
    err_d      = err_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{idx: req_idx, data: req_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      wr_en_d    = 1'b1;
      wr_sel_d   = head.idx;
      wr_data_d  = head.data;
      wr_count_d = wr_count_q + 8'd1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A new illegal accept outranks a simultaneous clear.
    if (illegal_acc)  err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign wr_en       = wr_en_q;
  assign wr_sel      = wr_sel_q;
  assign wr_data     = wr_data_q;
  assign wr_count    = wr_count_q;
  assign illegal_err = err_q;
  assign fifo_level  = level_q;

endmodule
